mopshub_hub_ctrl: RTL and testbench

Central controller of the MOPSHUB readout hub. It sequences bus start-up: bus reset, per-bus power-up, optional per-bus oscillator trimming and sign-on. It then routes 76-bit CANopen frames between the elink side and up to 16 CAN buses. Elink serialisation, SPI power control and the CAN cores are external and connect through this block's flat handshake ports.

---
 rtl/mopshub_pkg.sv | 24 ++
 rtl/mopshub_wait_timer.sv | 33 +++
 rtl/mopshub_hub_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mopshub_hub_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_pkg.sv
// rtl/mopshub_pkg.sv - shared types and constants for the MOPSHUB hub controller
package mopshub_pkg;

    localparam int FRAME_W   = 76;
    localparam int MAX_BUSES = 16;

    // Frame layout: {cob_id[10:0], rtr, payload[63:0]}
    localparam int COB_ID_LSB  = 65;
    localparam int COB_ID_W    = 11;
    localparam int RTR_BIT     = 64;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_POWER,
        ST_TRIM,
        ST_SIGN_ON,
        ST_RUN,
        ST_WAIT
    } hub_state_t;

endpackage

// File: rtl/mopshub_wait_timer.sv
// rtl/mopshub_wait_timer.sv - loadable down-counter with single-cycle expiry flag
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          load load_val into the counter (takes priority over counting)
//   load_val      number of cycles until expiry, counted from the cycle after load
//   expire        high during the load_val-th cycle after the load edge
module mopshub_wait_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Counter sits at zero once spent, so expiry fires exactly once per load.
    assign expire = (count == W'(1));

endmodule

// File: rtl/mopshub_hub_ctrl.sv
// rtl/mopshub_hub_ctrl.sv - MOPSHUB hub controller: bus start-up sequencing and elink/CAN frame routing
//
// Optional feature macro: MOPSHUB_AUTO_TRIM_EN (adds the per-bus oscillator trim phase).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   n_buses                        populated bus count (0 -> 1, >16 -> 16)
//   osc_auto_trim_mopshub          request trim phase at end of power-up
//   trim_done                      current bus trim finished
//   endwait_all                    abort pending response wait
//   elink_rx_valid/bus/data        downlink frame in; elink_rx_ready accepts it
//   can_rec_valid/bus/data         frame received from a CAN bus
//   data_tra_downlink, can_tra_select, can_tra_valid   frame out to CAN
//   data_rec_uplink, can_rec_select, elink_tx_valid    frame out to elink
//   irq_elink_tra, irq_elink_rec, timeout_err          event pulses
//   start_init, end_init, rst_bus, power_bus_en, end_power_init,
//   start_trim_ack, end_trim_bus, sign_on_sig          start-up status
//   power_bus_cnt                  bus being powered or trimmed
module mopshub_hub_ctrl
    import mopshub_pkg::*;
#(
    parameter int PWR_WAIT     = 16,
    parameter int RST_CYCLES   = 4,
    parameter int TRIM_TIMEOUT = 1024,
    parameter int RESP_TIMEOUT = 4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         n_buses,
    input  logic               osc_auto_trim_mopshub,
    input  logic               trim_done,
    input  logic               endwait_all,
    input  logic               elink_rx_valid,
    input  logic [4:0]         elink_rx_bus,
    input  logic [FRAME_W-1:0] elink_rx_data,
    output logic               elink_rx_ready,
    input  logic               can_rec_valid,
    input  logic [4:0]         can_rec_bus,
    input  logic [FRAME_W-1:0] can_rec_data,
    output logic [FRAME_W-1:0] data_tra_downlink,
    output logic [4:0]         can_tra_select,
    output logic               can_tra_valid,
    output logic [FRAME_W-1:0] data_rec_uplink,
    output logic [4:0]         can_rec_select,
    output logic               elink_tx_valid,
    output logic               irq_elink_tra,
    output logic               irq_elink_rec,
    output logic               timeout_err,
    output logic               start_init,
    output logic               end_init,
    output logic               rst_bus,
    output logic               power_bus_en,
    output logic               end_power_init,
    output logic               start_trim_ack,
    output logic               end_trim_bus,
    output logic               sign_on_sig,
    output logic [4:0]         power_bus_cnt
);

    hub_state_t  state, state_nxt;
    logic [4:0]  n_eff;
    logic [4:0]  bus_idx;
    logic        last_bus;
    logic        step_start;     // first cycle after the timer was (re)loaded
    logic        end_power_q;    // first cycle after POWER
    logic        tmr_load;
    logic [15:0] tmr_val;
    logic        tmr_expire;
    logic        idx_inc;
    logic        idx_clr;
    logic        dl_fwd;
    logic        ul_take;
    logic        resp_match;

    always_comb begin
        if (n_buses == 5'd0) begin
            n_eff = 5'd1;
        end else if (n_buses > 5'(MAX_BUSES)) begin
            n_eff = 5'(MAX_BUSES);
        end else begin
            n_eff = n_buses;
        end
    end

    assign last_bus   = (bus_idx == n_eff - 5'd1);
    assign resp_match = can_rec_valid && (can_rec_bus == can_tra_select);
    assign ul_take    = can_rec_valid && ((state == ST_RUN) || (state == ST_WAIT));

    mopshub_wait_timer #(.W(16)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        idx_inc      = 1'b0;
        idx_clr      = 1'b0;
        dl_fwd       = 1'b0;
        timeout_err  = 1'b0;
        end_trim_bus = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_INIT;
                tmr_load  = 1'b1;
                tmr_val   = 16'(RST_CYCLES);
            end
            ST_INIT: begin
                if (tmr_expire) begin
                    state_nxt = ST_POWER;
                    tmr_load  = 1'b1;
                    tmr_val   = 16'(PWR_WAIT);
                    idx_clr   = 1'b1;
                end
            end
            ST_POWER: begin
                if (tmr_expire) begin
                    if (last_bus) begin
                        idx_clr = 1'b1;
`ifdef MOPSHUB_AUTO_TRIM_EN
                        if (osc_auto_trim_mopshub) begin
                            state_nxt = ST_TRIM;
                            tmr_load  = 1'b1;
                            tmr_val   = 16'(TRIM_TIMEOUT);
                        end else begin
                            state_nxt = ST_SIGN_ON;
                        end
`else
                        state_nxt = ST_SIGN_ON;
`endif
                    end else begin
                        idx_inc  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = 16'(PWR_WAIT);
                    end
                end
            end
            ST_TRIM: begin
`ifdef MOPSHUB_AUTO_TRIM_EN
                if (trim_done || tmr_expire) begin
                    end_trim_bus = 1'b1;
                    timeout_err  = !trim_done;
                    if (last_bus) begin
                        state_nxt = ST_SIGN_ON;
                    end else begin
                        idx_inc  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = 16'(TRIM_TIMEOUT);
                    end
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_SIGN_ON: begin
                // Coming from POWER, end_power_init gets its own cycle first.
                if (!end_power_q) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (elink_rx_valid && (elink_rx_bus < n_eff)) begin
                    dl_fwd    = 1'b1;
                    state_nxt = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = 16'(RESP_TIMEOUT);
                end
            end
            ST_WAIT: begin
                // A response or abort in the expiry cycle wins over the timeout.
                if (resp_match || endwait_all) begin
                    state_nxt = ST_RUN;
                end else if (tmr_expire) begin
                    timeout_err = 1'b1;
                    state_nxt   = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_idx           <= '0;
            step_start        <= 1'b0;
            end_power_q       <= 1'b0;
            data_tra_downlink <= '0;
            can_tra_select    <= '0;
            can_tra_valid     <= 1'b0;
            irq_elink_tra     <= 1'b0;
            data_rec_uplink   <= '0;
            can_rec_select    <= '0;
            elink_tx_valid    <= 1'b0;
            irq_elink_rec     <= 1'b0;
        end else begin
            step_start    <= tmr_load;
            end_power_q   <= (state == ST_POWER) && (state_nxt != ST_POWER);
            can_tra_valid <= dl_fwd;
            irq_elink_tra <= dl_fwd;
            elink_tx_valid <= ul_take;
            irq_elink_rec  <= ul_take;
            if (idx_clr) begin
                bus_idx <= '0;
            end else if (idx_inc) begin
                bus_idx <= bus_idx + 5'd1;
            end
            if (dl_fwd) begin
                data_tra_downlink <= elink_rx_data;
                can_tra_select    <= elink_rx_bus;
            end
            if (ul_take) begin
                data_rec_uplink <= can_rec_data;
                can_rec_select  <= can_rec_bus;
            end
        end
    end

    assign elink_rx_ready = (state == ST_RUN);
    assign start_init     = (state == ST_INIT) && step_start;
    assign rst_bus        = (state == ST_INIT);
    assign power_bus_en   = (state == ST_POWER);
    assign end_power_init = end_power_q;
    assign sign_on_sig    = (state == ST_SIGN_ON) && !end_power_q;
    assign end_init       = sign_on_sig;
    assign power_bus_cnt  = ((state == ST_POWER) || (state == ST_TRIM)) ? bus_idx : 5'd0;

`ifdef MOPSHUB_AUTO_TRIM_EN
    assign start_trim_ack = (state == ST_TRIM) && step_start;
`else
    logic unused_trim;
    assign unused_trim    = osc_auto_trim_mopshub ^ trim_done ^ (TRIM_TIMEOUT == 0);
    assign start_trim_ack = 1'b0;
`endif

endmodule

// File: tb/tb_mopshub_hub_ctrl.sv
// tb/tb_mopshub_hub_ctrl.sv - self-checking bench for mopshub_hub_ctrl
module tb_mopshub_hub_ctrl;
    import mopshub_pkg::*;

    localparam int PW = 16;
    localparam int RC = 4;
    localparam int TT = 1024;
    localparam int RT = 4000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [4:0]         n_buses = 5'd2;
    logic               osc_auto_trim_mopshub = 1'b0;
    logic               trim_done = 1'b0;
    logic               endwait_all = 1'b0;
    logic               elink_rx_valid = 1'b0;
    logic [4:0]         elink_rx_bus = '0;
    logic [FRAME_W-1:0] elink_rx_data = '0;
    logic               elink_rx_ready;
    logic               can_rec_valid = 1'b0;
    logic [4:0]         can_rec_bus = '0;
    logic [FRAME_W-1:0] can_rec_data = '0;
    logic [FRAME_W-1:0] data_tra_downlink;
    logic [4:0]         can_tra_select;
    logic               can_tra_valid;
    logic [FRAME_W-1:0] data_rec_uplink;
    logic [4:0]         can_rec_select;
    logic               elink_tx_valid;
    logic               irq_elink_tra;
    logic               irq_elink_rec;
    logic               timeout_err;
    logic               start_init;
    logic               end_init;
    logic               rst_bus;
    logic               power_bus_en;
    logic               end_power_init;
    logic               start_trim_ack;
    logic               end_trim_bus;
    logic               sign_on_sig;
    logic [4:0]         power_bus_cnt;

    mopshub_hub_ctrl #(
        .PWR_WAIT(PW), .RST_CYCLES(RC), .TRIM_TIMEOUT(TT), .RESP_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rst(rst), .n_buses(n_buses),
        .osc_auto_trim_mopshub(osc_auto_trim_mopshub), .trim_done(trim_done),
        .endwait_all(endwait_all),
        .elink_rx_valid(elink_rx_valid), .elink_rx_bus(elink_rx_bus),
        .elink_rx_data(elink_rx_data), .elink_rx_ready(elink_rx_ready),
        .can_rec_valid(can_rec_valid), .can_rec_bus(can_rec_bus), .can_rec_data(can_rec_data),
        .data_tra_downlink(data_tra_downlink), .can_tra_select(can_tra_select),
        .can_tra_valid(can_tra_valid),
        .data_rec_uplink(data_rec_uplink), .can_rec_select(can_rec_select),
        .elink_tx_valid(elink_tx_valid),
        .irq_elink_tra(irq_elink_tra), .irq_elink_rec(irq_elink_rec), .timeout_err(timeout_err),
        .start_init(start_init), .end_init(end_init), .rst_bus(rst_bus),
        .power_bus_en(power_bus_en), .end_power_init(end_power_init),
        .start_trim_ack(start_trim_ack), .end_trim_bus(end_trim_bus),
        .sign_on_sig(sign_on_sig), .power_bus_cnt(power_bus_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Uplink expected in the cycle currently being sampled.
    bit           up_pend = 1'b0;
    logic [4:0]   up_bus  = '0;
    logic [75:0]  up_data = '0;

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [75:0] rand76();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[75:0];
    endfunction

    function automatic logic [16:0] seq_vec();
        return {start_init, end_init, rst_bus, power_bus_en, end_power_init,
                start_trim_ack, end_trim_bus, sign_on_sig, power_bus_cnt,
                elink_rx_ready, timeout_err, can_tra_valid, elink_tx_valid};
    endfunction

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance(input bit live);
        up_pend = live && can_rec_valid;
        up_bus  = can_rec_bus;
        up_data = can_rec_data;
        @(posedge clk);
        #1;
        elink_rx_valid = 1'b0;
        can_rec_valid  = 1'b0;
        endwait_all    = 1'b0;
        trim_done      = 1'b0;
    endtask

    task automatic check_uplink(input string tag);
        check({tag, " elink_tx_valid"}, elink_tx_valid, up_pend);
        check({tag, " irq_elink_rec"}, irq_elink_rec, up_pend);
        if (up_pend) begin
            check({tag, " can_rec_select"}, can_rec_select, up_bus);
            check({tag, " data_rec_uplink"}, data_rec_uplink, up_data);
        end
    endtask

    // Start-up trace predicted from cycle arithmetic: cycle 0 is the IDLE cycle after release.
    task automatic startup(input int n_cfg, input bit osc, input bit do_reset);
        int n, pend;
        bit pon;
        logic [4:0] cnt;
        logic [16:0] e;
        n = (n_cfg == 0) ? 1 : (n_cfg > 16) ? 16 : n_cfg;
        pend = RC + n * PW;
        n_buses = 5'(n_cfg);
        osc_auto_trim_mopshub = osc;
        if (do_reset) begin
            rst = 1'b1;
            sample();
            advance(1'b0);
        end
        rst = 1'b0;
        for (int c = 0; c <= pend + 3; c++) begin
            trim_done     = 1'($urandom_range(0, 1));
            can_rec_valid = (c < pend + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            can_rec_bus   = 5'($urandom_range(0, 15));
            can_rec_data  = rand76();
            sample();
            pon = (c > RC) && (c <= pend);
            cnt = pon ? 5'((c - RC - 1) / PW) : 5'd0;
            e = {c == 1, c == pend + 2, (c >= 1) && (c <= RC), pon, c == pend + 1,
                 1'b0, 1'b0, c == pend + 2, cnt, c >= pend + 3, 1'b0, 1'b0, 1'b0};
            check($sformatf("startup n=%0d c=%0d", n_cfg, c), seq_vec(), e);
            if (c == 0) begin
                check("reset data_tra_downlink", data_tra_downlink, '0);
                check("reset data_rec_uplink", data_rec_uplink, '0);
                check("reset selects/irqs",
                      {can_tra_select, can_rec_select, irq_elink_tra, irq_elink_rec}, '0);
            end
            advance(1'b0);
        end
    endtask

    task automatic run_txn(input int n);
        logic [4:0]  bus, obus;
        logic [75:0] data;
        int d, kind, last;
        bit fwd;
        bus  = 5'($urandom_range(0, n + 2));
        data = rand76();
        elink_rx_valid = 1'b1;
        elink_rx_bus   = bus;
        elink_rx_data  = data;
        can_rec_valid  = 1'($urandom_range(0, 1));
        can_rec_bus    = 5'($urandom_range(0, 15));
        can_rec_data   = rand76();
        sample();
        check("txn ready", elink_rx_ready, 1'b1);
        check_uplink("txn pre");
        advance(1'b1);
        fwd = (int'(bus) < n);
        if (!fwd) begin
            sample();
            check("drop can_tra_valid", can_tra_valid, 1'b0);
            check("drop ready", elink_rx_ready, 1'b1);
            check_uplink("drop");
            advance(1'b1);
            return;
        end
        d    = $urandom_range(1, 12);
        kind = $urandom_range(0, 3);
        last = d + ((kind == 1) ? 1 : 0);
        obus = bus + 5'd1;
        for (int w = 1; w <= last; w++) begin
            if (kind == 1 && w == d) begin
                can_rec_valid = 1'b1; can_rec_bus = obus; can_rec_data = rand76();
            end else if (w == last) begin
                if (kind != 2) begin
                    can_rec_valid = 1'b1; can_rec_bus = bus; can_rec_data = rand76();
                end
                if (kind >= 2) endwait_all = 1'b1;
            end
            sample();
            check($sformatf("wait w=%0d can_tra_valid", w), can_tra_valid, w == 1);
            check($sformatf("wait w=%0d irq_elink_tra", w), irq_elink_tra, w == 1);
            if (w == 1) begin
                check("dl can_tra_select", can_tra_select, bus);
                check("dl data_tra_downlink", data_tra_downlink, data);
            end
            check($sformatf("wait w=%0d ready", w), elink_rx_ready, 1'b0);
            check($sformatf("wait w=%0d timeout_err", w), timeout_err, 1'b0);
            check_uplink("wait");
            advance(1'b1);
        end
        sample();
        check("post-wait ready", elink_rx_ready, 1'b1);
        check_uplink("post-wait");
        advance(1'b1);
    endtask

    // mode 0: silent bus, mode 1: endwait_all at 50, mode 2: response+endwait at expiry cycle
    task automatic run_timeout(input int mode);
        int early;
        bit done;
        early = 0;
        elink_rx_valid = 1'b1;
        elink_rx_bus   = 5'd0;
        elink_rx_data  = rand76();
        sample();
        check("to ready", elink_rx_ready, 1'b1);
        advance(1'b1);
        for (int w = 1; w <= RT; w++) begin
            if (mode == 1 && w == 50) endwait_all = 1'b1;
            if (mode == 2 && w == RT) begin
                endwait_all = 1'b1;
                can_rec_valid = 1'b1; can_rec_bus = 5'd0; can_rec_data = rand76();
            end
            sample();
            if (w == RT - 1 || w == RT || (mode == 1 && w == 50)) begin
                check($sformatf("timeout_err m%0d w%0d", mode, w), timeout_err,
                      (mode == 0) && (w == RT));
                check($sformatf("to ready m%0d w%0d", mode, w), elink_rx_ready, 1'b0);
            end else if (timeout_err !== 1'b0) begin
                early++;
            end
            done = (mode == 1) && (w == 50);
            advance(1'b1);
            if (done) break;
        end
        sample();
        check($sformatf("to m%0d stray timeout_err", mode), early, 0);
        check($sformatf("to m%0d ready after", mode), elink_rx_ready, 1'b1);
        check($sformatf("to m%0d timeout_err after", mode), timeout_err, 1'b0);
        check_uplink("to");
        advance(1'b1);
    endtask

`ifdef MOPSHUB_AUTO_TRIM_EN
    task automatic trim_test();
        int pend;
        logic [4:0] cnt;
        pend = RC + 2 * PW;
        n_buses = 5'd2;
        osc_auto_trim_mopshub = 1'b1;
        rst = 1'b1;
        sample();
        advance(1'b0);
        rst = 1'b0;
        for (int c = 0; c <= pend + 24; c++) begin
            trim_done = (c == pend + 11) || (c == pend + 22);
            sample();
            if (c > pend) begin
                cnt = (c <= pend + 11) ? 5'd0 : (c <= pend + 22) ? 5'd1 : 5'd0;
                check($sformatf("trim c=%0d", c),
                      {start_trim_ack, end_trim_bus, sign_on_sig, power_bus_cnt, elink_rx_ready, timeout_err},
                      {(c == pend + 1) || (c == pend + 12), (c == pend + 11) || (c == pend + 22),
                       c == pend + 23, cnt, c == pend + 24, 1'b0});
            end
            advance(1'b0);
        end
        osc_auto_trim_mopshub = 1'b0;
    endtask
`endif

    initial begin
        int nr;
        @(posedge clk);
        #1;

        startup(2, 1'b0, 1'b1);

        // Directed downlink/uplink round trip on bus 1
        elink_rx_valid = 1'b1;
        elink_rx_bus   = 5'd1;
        elink_rx_data  = 76'hABC_0123456789ABCDEF;
        sample();
        check("dir ready", elink_rx_ready, 1'b1);
        advance(1'b1);
        sample();
        check("dir can_tra_valid", can_tra_valid, 1'b1);
        check("dir irq_elink_tra", irq_elink_tra, 1'b1);
        check("dir can_tra_select", can_tra_select, 5'd1);
        check("dir data_tra_downlink", data_tra_downlink, 76'hABC_0123456789ABCDEF);
        check("dir ready in wait", elink_rx_ready, 1'b0);
        advance(1'b1);
        can_rec_valid = 1'b1;
        can_rec_bus   = 5'd1;
        can_rec_data  = 76'h123_FEDCBA9876543210;
        sample();
        check("dir can_tra_valid single", can_tra_valid, 1'b0);
        advance(1'b1);
        sample();
        check_uplink("dir");
        check("dir ready again", elink_rx_ready, 1'b1);
        advance(1'b1);

        // Out-of-range bus is dropped
        elink_rx_valid = 1'b1;
        elink_rx_bus   = 5'd5;
        elink_rx_data  = rand76();
        sample();
        advance(1'b1);
        sample();
        check("bus5 can_tra_valid", can_tra_valid, 1'b0);
        check("bus5 ready", elink_rx_ready, 1'b1);
        advance(1'b1);

        repeat (20) run_txn(2);

        run_timeout(0);
        run_timeout(1);
        run_timeout(2);

        // Reset while waiting: pending uplink and wait are discarded, sequence restarts
        elink_rx_valid = 1'b1;
        elink_rx_bus   = 5'd1;
        elink_rx_data  = rand76();
        sample();
        advance(1'b1);
        sample();
        advance(1'b1);
        rst = 1'b1;
        can_rec_valid = 1'b1;
        can_rec_bus   = 5'd1;
        can_rec_data  = rand76();
        sample();
        advance(1'b0);
        startup(2, 1'b0, 1'b0);

        startup(0, 1'b0, 1'b1);
        repeat (8) run_txn(1);
        startup(20, 1'b0, 1'b1);
        repeat (8) run_txn(16);
        nr = $urandom_range(1, 16);
        startup(nr, 1'b0, 1'b1);
        repeat (10) run_txn(nr);

`ifdef MOPSHUB_AUTO_TRIM_EN
        trim_test();
`else
        startup(3, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
